// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access size encoding, FSM states
// and the request legality check used at acceptance time.
package dmem_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   // Misaligned, illegal-size and out-of-range requests are all rejected.
   function automatic logic access_err(input logic [31:0] addr, input size_e size,
                                       input int unsigned depth);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addr[0];
         SIZE_WORD: bad = |addr[1:0];
         default:   bad = 1'b1;
      endcase
      if ({2'b00, addr[31:2]} >= depth) bad = 1'b1;
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: byte enables and replicated store data for the
// array write, and lane extraction plus sign/zero extension for loads.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  size_e       size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wlane_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
   assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

   always_comb begin
      be_o    = 4'b0000;
      wlane_o = wdata_i;
      rdata_o = '0;
      case (size_i)
         SIZE_BYTE: begin
            be_o    = 4'b0001 << addr_lo_i;
            wlane_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         end
         SIZE_HALF: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wlane_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         end
         SIZE_WORD: begin
            be_o    = 4'b1111;
            rdata_o = rword_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder: word array with byte-lane stores,
// configurable wait states and a held response until the initiator accepts it.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          we_q, uns_q;
   logic [31:0]   addr_q, wdata_q;
   size_e         size_q;
   logic          rsp_valid_q, rsp_err_q;
   logic [31:0]   rsp_rdata_q;

   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          idle_d, req_err_d, commit_d, mem_we_d;
   logic          acc_we_d, acc_uns_d;
   logic [31:0]   acc_addr_d, acc_wdata_d, rword_d;
   size_e         acc_size_d;
   logic [AW-1:0] idx_d;
   logic [3:0]    be_d;
   logic [31:0]   wlane_d, load_d;

   assign idle_d    = (state_q == IDLE);
   assign req_err_d = access_err(req_addr_i, size_e'(req_size_i), DEPTH_WORDS);

   // With zero wait states the access happens on the accept edge, so the
   // datapath must see the live request rather than the latched copy.
   always_comb begin
      acc_we_d    = we_q;
      acc_uns_d   = uns_q;
      acc_addr_d  = addr_q;
      acc_wdata_d = wdata_q;
      acc_size_d  = size_q;
      if (idle_d) begin
         acc_we_d    = req_we_i;
         acc_uns_d   = req_unsigned_i;
         acc_addr_d  = req_addr_i;
         acc_wdata_d = req_wdata_i;
         acc_size_d  = size_e'(req_size_i);
      end
   end

   assign commit_d = (idle_d && req_valid_i && !req_err_d && (WAIT_CYCLES == 0))
                   || (state_q == WAIT && cnt_q == CNT_LAST);
   assign mem_we_d = commit_d && acc_we_d && rst_ni;
   assign idx_d    = acc_addr_d[AW+1:2];
   assign rword_d  = mem_q[idx_d];

   dmem_lane_align u_lane_align (
      .addr_lo_i  (acc_addr_d[1:0]),
      .size_i     (acc_size_d),
      .unsigned_i (acc_uns_d),
      .wdata_i    (acc_wdata_d),
      .rword_i    (rword_d),
      .be_o       (be_d),
      .wlane_o    (wlane_d),
      .rdata_o    (load_d)
   );

   always_ff @(posedge clk_i) begin
      if (mem_we_d) begin
         for (int i = 0; i < 4; i++) begin
            if (be_d[i]) mem_q[idx_d][8*i +: 8] <= wlane_d[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= SIZE_BYTE;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  we_q    <= req_we_i;
                  uns_q   <= req_unsigned_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  size_q  <= size_e'(req_size_i);
                  cnt_q   <= '0;
                  if (req_err_d) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else if (WAIT_CYCLES == 0) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_rdata_q <= req_we_i ? 32'h0 : load_d;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == CNT_LAST) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= we_q ? 32'h0 : load_d;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o = idle_d;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores/loads of each size, error cases,
// response backpressure and reset during a pending store.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WAITC = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_unsigned_i = 1'b0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;

   int total = 0;
   int passed = 0;
   int failed = 0;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready_i),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one request and consume its accept edge; sampling resumes 1ns later.
   task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns);
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_addr_i     = addr;
      req_wdata_i    = wd;
      req_size_i     = sz;
      req_unsigned_i = uns;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
   endtask

   // Edges from the accept edge (counted as 1) until rsp_valid_o is seen.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid_o && lat < 20) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
   endtask

   task automatic access(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      int lat;
      rsp_ready_i = 1'b1;
      send(we, addr, wd, sz, uns);
      wait_rsp(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_rdata"}, rsp_rdata_o, exp_rd);
      chk({tag, "_err"}, {31'b0, rsp_err_o}, {31'b0, exp_err});
      @(posedge clk_i);
      #1;
      chk({tag, "_idle"}, {30'b0, req_ready_o, rsp_valid_o}, 32'h2);
      $display("txn %s we=%0b addr=0x%08h size=%0d -> rdata=0x%08h err=%0b lat=%0d",
               tag, we, addr, sz, exp_rd, exp_err, lat);
   endtask

   initial begin
      int lat;

      // Reset state
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_outputs", {29'b0, rsp_valid_o, rsp_err_o, |rsp_rdata_o}, 32'h0);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      chk("rst_ready", {31'b0, req_ready_o}, 32'h1);

      // Word store/load with full latency
      access("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, WAITC + 1);
      access("ld_w10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, WAITC + 1);

      // Byte lane 3 store, signed/unsigned loads
      access("st_b13", 1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, 32'h0, 1'b0, WAITC + 1);
      access("ld_bs13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, WAITC + 1);
      access("ld_bu13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0, WAITC + 1);
      access("ld_w10b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, WAITC + 1);

      // Misaligned accesses respond after one edge
      access("ld_h11", 1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1);
      access("ld_w12", 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1);
      access("st_h11", 1'b1, 32'h11, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1);
      access("ld_w10c", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, WAITC + 1);

      // Out-of-range store must not alias onto word 0; illegal size rejected
      access("st_w00", 1'b1, 32'h0, 32'h11223344, 2'b10, 1'b0, 32'h0, 1'b0, WAITC + 1);
      access("st_oor", 1'b1, 4 * DEPTH, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, 1'b1, 1);
      access("st_oorb", 1'b1, 4 * DEPTH + 1, 32'hFFFFFFFF, 2'b00, 1'b0, 32'h0, 1'b1, 1);
      access("ld_w00", 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b0, WAITC + 1);
      access("ld_sz3", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1);
      access("ld_lastw", 1'b0, 4 * DEPTH - 4, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1);

      // Halfword lanes
      access("st_w14", 1'b1, 32'h14, 32'h01234567, 2'b10, 1'b0, 32'h0, 1'b0, WAITC + 1);
      access("st_h16", 1'b1, 32'h16, 32'h1234CAFE, 2'b01, 1'b0, 32'h0, 1'b0, WAITC + 1);
      access("ld_w14", 1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 32'hCAFE4567, 1'b0, WAITC + 1);
      access("ld_hs16", 1'b0, 32'h16, 32'h0, 2'b01, 1'b0, 32'hFFFFCAFE, 1'b0, WAITC + 1);
      access("ld_hu14", 1'b0, 32'h14, 32'h0, 2'b01, 1'b1, 32'h00004567, 1'b0, WAITC + 1);
      access("ld_bs14", 1'b0, 32'h14, 32'h0, 2'b00, 1'b0, 32'h00000067, 1'b0, WAITC + 1);

      // Response backpressure; a store presented meanwhile must be ignored
      rsp_ready_i = 1'b0;
      send(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
      wait_rsp(lat);
      chk("bp_lat", 32'(lat), 32'(WAITC + 1));
      req_valid_i = 1'b1;
      req_we_i    = 1'b1;
      req_addr_i  = 32'h10;
      req_wdata_i = 32'h0;
      req_size_i  = 2'b10;
      for (int i = 0; i < 5; i++) begin
         chk("bp_rdata", rsp_rdata_o, 32'h80ADBEEF);
         chk("bp_flags", {29'b0, rsp_valid_o, rsp_err_o, req_ready_o}, 32'h4);
         @(posedge clk_i);
         #1;
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      chk("bp_release", {30'b0, req_ready_o, rsp_valid_o}, 32'h2);
      $display("txn bp_hold load addr=0x00000010 held 5 cycles rdata=0x80ADBEEF");
      access("ld_w10d", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, WAITC + 1);

      // Reset while a store sits in WAIT
      access("st_w20", 1'b1, 32'h20, 32'h0BADF00D, 2'b10, 1'b0, 32'h0, 1'b0, WAITC + 1);
      send(1'b1, 32'h20, 32'hFFFFFFFF, 2'b10, 1'b0);
      chk("mid_wait", {30'b0, req_ready_o, rsp_valid_o}, 32'h0);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst", {30'b0, req_ready_o, rsp_valid_o}, 32'h2);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      chk("post_rst", {30'b0, req_ready_o, rsp_valid_o}, 32'h2);
      $display("txn rst_abort store addr=0x00000020 aborted");
      access("ld_w20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0BADF00D, 1'b0, WAITC + 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra wait states per access (0 allowed).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready_o  output  1  responder can accept a request.
REQ-007 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr_i  input  32  byte address.
REQ-009 SHALL have port req_wdata_i  input  32  store data, right-aligned.
REQ-010 SHALL have port req_size_i  input  2  00 byte, 01 half, 10 word; 11 illegal.
REQ-011 SHALL have port req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port rsp_valid_o  output  1  response available.
REQ-013 SHALL have port rsp_ready_i  input  1  initiator accepts the response.
REQ-014 SHALL have port rsp_rdata_o  output  32  load data, extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err_o  output  1  access rejected (misaligned, out of range, or illegal size).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where req_valid_i and req_ready_o are both 1, latching we, addr, wdata, size, unsigned.
REQ-018 SHALL flag error when size=11, size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or addr[31:2] >= DEPTH_WORDS.
REQ-019 SHALL, on error, go IDLE->RESP next edge with rsp_err_o=1, rsp_rdata_o=0, and no array write.
REQ-020 SHALL, without error, go IDLE->WAIT when WAIT_CYCLES>0 (stay exactly WAIT_CYCLES cycles) or IDLE->RESP when WAIT_CYCLES=0.
REQ-021 SHALL perform the array write and the load data capture on the edge entering RESP, exactly once per request.
REQ-022 SHALL give latency: accept at edge N, rsp_valid_o high after edge N+WAIT_CYCLES+1.
REQ-023 SHALL use little-endian lanes: byte store writes lane addr[1:0] only; half store writes lanes addr[1]*2 and +1; word store writes all four.
REQ-024 SHALL extract load byte/half from the same lanes and extend to 32 bits per req_unsigned_i.
REQ-025 SHALL hold rsp_valid_o, rsp_rdata_o, rsp_err_o stable in RESP until rsp_ready_i=1, then return to IDLE on that edge.
REQ-026 SHALL NOT accept a new request in the cycle of the response handshake; next acceptance is earliest on the following edge.
REQ-027 SHALL ignore req_* inputs outside IDLE; changes after acceptance do not affect the pending access.

Reset
REQ-028 SHALL on rst_ni=0 force state IDLE, wait counter 0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, req_ready_o=1 after release.
REQ-029 SHALL abort a pending access on reset mid-operation; a store not yet in RESP SHALL leave the array unchanged.
REQ-030 SHALL NOT reset the memory array contents.

Structure
REQ-031 SHALL place the size encoding enum and FSM state enum in shared package dmem_pkg.
REQ-032 SHALL place lane select, byte-enable generation and load extension in one combinational sub-module dmem_lane_align.

Verification
REQ-033 Store word 0xDEADBEEF @0x10, load word @0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid after WAIT_CYCLES+1 edges.
REQ-034 Store byte 0x80 @0x13, load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80ADBEEF.
REQ-035 Load half @0x11 and word @0x12 -> err 1, rdata 0, response one edge after accept; memory unchanged.
REQ-036 Store @ byte address 4*DEPTH_WORDS -> err 1, no write; size=11 -> err 1.
REQ-037 Hold rsp_ready_i=0 for 5 cycles -> rsp_* stable, req_ready_o=0; release -> IDLE next edge.
REQ-038 Assert rst_ni=0 during WAIT of a store to 0x20 -> IDLE, rsp_valid_o=0; subsequent load @0x20 returns the old value.
